regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 96 +++++++++
 tb/tb_regfile_mp.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-ported register file with per-register pending (scoreboard) bits.
// x0 is hardwired to zero and is never pending.
// Optional macro REGFILE_MP_BYPASS_EN: forward same-cycle write data to matching read ports.
module regfile_mp #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned READ_PORTS  = 2,
  parameter int unsigned WRITE_PORTS = 2
) (
  input  logic                                   clk,
  input  logic                                   sync_rst,
  input  logic [WRITE_PORTS-1:0]                 write_enable,
  input  logic [WRITE_PORTS-1:0][ADDR_WIDTH-1:0] write_addr,
  input  logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0] write_data,
  input  logic                                   issue_valid,
  input  logic [ADDR_WIDTH-1:0]                  issue_addr,
  input  logic [READ_PORTS-1:0][ADDR_WIDTH-1:0]  read_addr,
  output logic [READ_PORTS-1:0][DATA_WIDTH-1:0]  read_data,
  output logic [READ_PORTS-1:0]                  read_ready,
  output logic                                   any_busy
);

  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

  // Storage starts at index 1; x0 has no flop behind it.
  logic [DATA_WIDTH-1:0] regs_q [1:NumRegs-1];
  logic [NumRegs-1:1]    pend_q;
  logic [NumRegs-1:1]    pend_d;

  // Register writes; later ports overwrite earlier ones so the highest port wins.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      for (int unsigned i = 1; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int unsigned p = 0; p < WRITE_PORTS; p++) begin
        if (write_enable[p] && (write_addr[p] != '0)) begin
          regs_q[write_addr[p]] <= write_data[p];
        end
      end
    end
  end

  // Pending next state: writes clear, an issue sets afterwards (a new producer wins).
  always_comb begin
    pend_d = pend_q;
    for (int unsigned i = 1; i < NumRegs; i++) begin
      for (int unsigned p = 0; p < WRITE_PORTS; p++) begin
        if (write_enable[p] && (write_addr[p] == ADDR_WIDTH'(i))) begin
          pend_d[i] = 1'b0;
        end
      end
      if (issue_valid && (issue_addr == ADDR_WIDTH'(i))) begin
        pend_d[i] = 1'b1;
      end
    end
  end

  // Pending bits; reset discards every in-flight producer.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // Combinational read ports with optional same-cycle forwarding.
  always_comb begin
    read_data  = '0;
    read_ready = '1;
    for (int unsigned r = 0; r < READ_PORTS; r++) begin
      if (read_addr[r] != '0) begin
        read_data[r]  = regs_q[read_addr[r]];
        read_ready[r] = ~pend_q[read_addr[r]];
`ifdef REGFILE_MP_BYPASS_EN
        if (!sync_rst) begin
          for (int unsigned p = 0; p < WRITE_PORTS; p++) begin
            if (write_enable[p] && (write_addr[p] == read_addr[r])) begin
              read_data[r]  = write_data[p];
              read_ready[r] = 1'b1;
            end
          end
        end
`endif
      end
    end
  end

  // Busy flag is a pure function of registered state.
  always_comb begin
    any_busy = |pend_q;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed vector table, corner sequences,
// then randomized traffic checked against an array-based reference model.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int RP = 2;
  localparam int WP = 2;
  localparam int NR = 2 ** AW;

  logic                   clk;
  logic                   sync_rst;
  logic [WP-1:0]          write_enable;
  logic [WP-1:0][AW-1:0]  write_addr;
  logic [WP-1:0][DW-1:0]  write_data;
  logic                   issue_valid;
  logic [AW-1:0]          issue_addr;
  logic [RP-1:0][AW-1:0]  read_addr;
  logic [RP-1:0][DW-1:0]  read_data;
  logic [RP-1:0]          read_ready;
  logic                   any_busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  logic [DW-1:0] m_regs [NR];
  logic          m_pend [NR];

  typedef struct {
    logic          rst;
    logic [1:0]    we;
    logic [AW-1:0] wa0;
    logic [DW-1:0] wd0;
    logic [AW-1:0] wa1;
    logic [DW-1:0] wd1;
    logic          iv;
    logic [AW-1:0] ia;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic [DW-1:0] d0;
    logic          r0;
    logic [DW-1:0] d1;
    logic          r1;
    logic          busy;
  } vec_t;

  vec_t tbl [13];

  regfile_mp #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .READ_PORTS (RP),
    .WRITE_PORTS(WP)
  ) dut (
    .clk         (clk),
    .sync_rst    (sync_rst),
    .write_enable(write_enable),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .read_addr   (read_addr),
    .read_data   (read_data),
    .read_ready  (read_ready),
    .any_busy    (any_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    sync_rst      = v.rst;
    write_enable  = v.we;
    write_addr[0] = v.wa0;
    write_data[0] = v.wd0;
    write_addr[1] = v.wa1;
    write_data[1] = v.wd1;
    issue_valid   = v.iv;
    issue_addr    = v.ia;
    read_addr[0]  = v.ra0;
    read_addr[1]  = v.ra1;
  endtask

  // Expected read value from the architectural rules.
  task automatic model_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic rdy);
    if (a == 0) begin
      d = '0;
      rdy = 1'b1;
    end else begin
      d = m_regs[a];
      rdy = !m_pend[a];
`ifdef REGFILE_MP_BYPASS_EN
      if (!sync_rst) begin
        for (int p = 0; p < WP; p++) begin
          if (write_enable[p] && write_addr[p] == a) begin
            d = write_data[p];
            rdy = 1'b1;
          end
        end
      end
`endif
    end
  endtask

  function automatic logic model_busy();
    for (int i = 0; i < NR; i++) if (m_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Advance the model with the current inputs, then clock the DUT.
  task automatic tick();
    if (sync_rst) begin
      for (int i = 0; i < NR; i++) begin
        m_regs[i] = '0;
        m_pend[i] = 1'b0;
      end
    end else begin
      for (int p = 0; p < WP; p++) begin
        if (write_enable[p] && write_addr[p] != 0) begin
          m_regs[write_addr[p]] = write_data[p];
          m_pend[write_addr[p]] = 1'b0;
        end
      end
      if (issue_valid && issue_addr != 0) m_pend[issue_addr] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    vec_t v;
    v = '{0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
    drive(v);
  endtask

  task automatic do_reset();
    idle_inputs();
    sync_rst = 1'b1;
    tick();
    sync_rst = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] ed;
    logic          er;
    vec_t          v;

    // rst, we, wa0, wd0, wa1, wd1, iv, ia, ra0, ra1 | d0, r0, d1, r1, busy
    tbl[0]  = '{0, 2'b00, 0, 0, 0, 0, 0, 0, 5, 0, 0, 1, 0, 1, 0};
    tbl[1]  = '{0, 2'b01, 5, 32'hDEADBEEF, 0, 0, 0, 0, 1, 2, 0, 1, 0, 1, 0};
    tbl[2]  = '{0, 2'b11, 7, 32'h11, 7, 32'h22, 0, 0, 5, 0, 32'hDEADBEEF, 1, 0, 1, 0};
    tbl[3]  = '{0, 2'b01, 0, 32'hFFFFFFFF, 0, 0, 1, 0, 7, 5, 32'h22, 1, 32'hDEADBEEF, 1, 0};
    tbl[4]  = '{0, 2'b00, 0, 0, 0, 0, 1, 3, 0, 7, 0, 1, 32'h22, 1, 0};
    tbl[5]  = '{0, 2'b00, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 1, 1};
    tbl[6]  = '{0, 2'b01, 3, 32'h5A, 0, 0, 1, 3, 5, 0, 32'hDEADBEEF, 1, 0, 1, 1};
    tbl[7]  = '{0, 2'b10, 0, 0, 3, 32'h77, 0, 0, 3, 5, 32'h5A, 0, 32'hDEADBEEF, 1, 1};
    tbl[8]  = '{0, 2'b00, 0, 0, 0, 0, 1, 4, 3, 0, 32'h77, 1, 0, 1, 0};
    tbl[9]  = '{1, 2'b01, 4, 32'h99, 0, 0, 1, 4, 4, 5, 0, 0, 32'hDEADBEEF, 1, 1};
    tbl[10] = '{0, 2'b00, 0, 0, 0, 0, 0, 0, 4, 5, 0, 1, 0, 1, 0};
    tbl[11] = '{0, 2'b01, 4, 32'h99, 0, 0, 0, 0, 0, 5, 0, 1, 0, 1, 0};
    tbl[12] = '{0, 2'b00, 0, 0, 0, 0, 0, 0, 4, 0, 32'h99, 1, 0, 1, 0};

    idle_inputs();
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i]);
      #1;
      check($sformatf("row%0d read_data0", i), read_data[0], tbl[i].d0);
      check($sformatf("row%0d read_ready0", i), DW'(read_ready[0]), DW'(tbl[i].r0));
      check($sformatf("row%0d read_data1", i), read_data[1], tbl[i].d1);
      check($sformatf("row%0d read_ready1", i), DW'(read_ready[1]), DW'(tbl[i].r1));
      check($sformatf("row%0d any_busy", i), DW'(any_busy), DW'(tbl[i].busy));
      tick();
    end

    // Write x9 while reading it: forwarded only in the bypass build.
    v = '{0, 2'b01, 9, 32'h1234, 0, 0, 0, 0, 9, 9, 0, 1, 0, 1, 0};
    drive(v);
    #1;
`ifdef REGFILE_MP_BYPASS_EN
    check("bypass same-cycle data", read_data[0], 32'h1234);
`else
    check("nobypass same-cycle data", read_data[0], 32'h0);
`endif
    check("same-cycle ready", DW'(read_ready[1]), 1);
    tick();
    idle_inputs();
    read_addr[0] = 9;
    #1;
    check("x9 next-cycle data", read_data[0], 32'h1234);
    check("x9 next-cycle ready", DW'(read_ready[0]), 1);

    // Randomized traffic against the reference model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      sync_rst     = ($urandom_range(0, 31) == 0);
      write_enable = WP'($urandom_range(0, 3));
      for (int p = 0; p < WP; p++) begin
        write_addr[p] = AW'($urandom_range(0, 7));
        write_data[p] = $urandom;
      end
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_addr  = AW'($urandom_range(0, 7));
      for (int r = 0; r < RP; r++) read_addr[r] = AW'($urandom_range(0, 7));
      #1;
      for (int r = 0; r < RP; r++) begin
        model_read(read_addr[r], ed, er);
        check($sformatf("rand%0d read_data%0d", n, r), read_data[r], ed);
        check($sformatf("rand%0d read_ready%0d", n, r), DW'(read_ready[r]), DW'(er));
      end
      check($sformatf("rand%0d any_busy", n), DW'(any_busy), DW'(model_busy()));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
